sign_restore: RTL and testbench

//  Re-applies the sign stripped off by the magnitude stage: two's-complement value = sign ? -mag : +mag.

---
 rtl/sign_restore_if.sv | 32 +++
 rtl/sign_restore.sv | 125 ++++++++++++
 tb/tb_sign_restore.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sign_restore_if.sv
// Handshake bundle for sign_restore: sign FIFO push side, magnitude
// input handshake and signed output handshake.
// The DUT connects through the slave modport; the driving side uses master.
interface sign_restore_if #(
    parameter int MAG_W = 16,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             sign_push;
    logic             sign_in;
    logic             sign_full;
    logic [CNT_W-1:0] sign_count;
    logic             sign_err;
    logic             mag_valid;
    logic [MAG_W-1:0] mag_in;
    logic             mag_ready;
    logic             out_valid;
    logic [MAG_W:0]   out_data;
    logic             out_ready;
    logic             sat_flag;

    modport slave (
        input  sign_push, sign_in, mag_valid, mag_in, out_ready,
        output sign_full, sign_count, sign_err, mag_ready, out_valid, out_data, sat_flag
    );

    modport master (
        output sign_push, sign_in, mag_valid, mag_in, out_ready,
        input  sign_full, sign_count, sign_err, mag_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/sign_restore.sv
// sign_restore: re-applies the sign removed by the magnitude stage.
// Signs are queued in a small FIFO when the value is stripped and popped in
// order as unsigned results come back; each result leaves as a MAG_W+1 bit
// two's-complement word through a single valid/ready register stage.
// Optional build macro SIGN_RESTORE_SAT16_EN clamps the result to the MAG_W-bit
// signed range and reports the clamp on sat_flag; without it sat_flag is 0.
module sign_restore #(
    parameter int MAG_W = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    sign_restore_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] sign_mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;

    logic             out_valid_q;
    logic [MAG_W:0]   out_data_q;

    logic             mag_ready_c;
    logic             pop;
    logic             push_ok;
    logic             sign_head;
    logic [MAG_W:0]   mag_ext;
    logic [MAG_W:0]   result;

`ifdef SIGN_RESTORE_SAT16_EN
    localparam logic [MAG_W-1:0] POS_MAX = {1'b0, {(MAG_W-1){1'b1}}};
    localparam logic [MAG_W-1:0] NEG_MAG = {1'b1, {(MAG_W-1){1'b0}}};
    logic sat_c;
    logic sat_q;
`endif

    // A result may only be taken once its sign is queued and the output
    // register is free (or being drained this same cycle).
    assign mag_ready_c = (count != '0) && (!out_valid_q || bus.out_ready);
    assign pop         = bus.mag_valid && mag_ready_c;
    // At full, a push is still accepted when a pop frees the slot this cycle.
    assign push_ok     = bus.sign_push && ((count != FULL_CNT) || pop);
    assign sign_head   = sign_mem[rd_ptr];

    // Sign FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sign_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                sign_mem[wr_ptr] <= bus.sign_in;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (bus.sign_push && !push_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    // Signed result for the head sign; negation in MAG_W+1 bits cannot overflow
    // and a zero magnitude negates back to zero.
    always_comb begin
        mag_ext = {1'b0, bus.mag_in};
        result  = sign_head ? (~mag_ext + (MAG_W+1)'(1)) : mag_ext;
`ifdef SIGN_RESTORE_SAT16_EN
        sat_c = 1'b0;
        if (!sign_head && (bus.mag_in > POS_MAX)) begin
            result = {1'b0, POS_MAX};
            sat_c  = 1'b1;
        end else if (sign_head && (bus.mag_in > NEG_MAG)) begin
            result = {1'b1, NEG_MAG};
            sat_c  = 1'b1;
        end
`endif
    end

    // Output register: load on accept, hold while stalled, drop valid when drained.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef SIGN_RESTORE_SAT16_EN
            sat_q       <= 1'b0;
`endif
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= result;
`ifdef SIGN_RESTORE_SAT16_EN
            sat_q       <= sat_c;
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.sign_full  = (count == FULL_CNT);
    assign bus.sign_count = count;
    assign bus.sign_err   = err_q;
    assign bus.mag_ready  = mag_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
`ifdef SIGN_RESTORE_SAT16_EN
    assign bus.sat_flag   = sat_q;
`else
    assign bus.sat_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_sign_restore.sv
// Directed bench for sign_restore: reset values, single conversions, ordered
// back-to-back results, FIFO full/overflow, output stall, empty-FIFO stall and
// mid-stream reset. Inputs change 1 ns after the rising edge, outputs are
// sampled 1 ns after the edge (registered) or 2 ns after it (combinational).
module tb_sign_restore;
    logic clk;
    logic n_rst;
    int   vectors;
    int   errors;

    sign_restore_if #(.MAG_W(16), .DEPTH(4)) bus ();

    sign_restore #(.MAG_W(16), .DEPTH(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s);
        bus.sign_push = 1'b1;
        bus.sign_in   = s;
        tick();
        bus.sign_push = 1'b0;
        bus.sign_in   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"},     32'(bus.sign_count), 32'd0);
        chk({tag, "_full"},      32'(bus.sign_full),  32'd0);
        chk({tag, "_err"},       32'(bus.sign_err),   32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid),  32'd0);
        chk({tag, "_out_data"},  32'(bus.out_data),   32'd0);
        chk({tag, "_sat"},       32'(bus.sat_flag),   32'd0);
        chk({tag, "_mag_ready"}, 32'(bus.mag_ready),  32'd0);
    endtask

    // One sign push followed by its magnitude; output checked one cycle later.
    task automatic xfer(input string tag, input logic s, input logic [15:0] m,
                        input logic [16:0] exp_data, input logic exp_sat);
        push(s);
        bus.mag_valid = 1'b1;
        bus.mag_in    = m;
        #1;
        chk({tag, "_ready"}, 32'(bus.mag_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.mag_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.out_data),  32'(exp_data));
        chk({tag, "_sat"},   32'(bus.sat_flag),  32'(exp_sat));
    endtask

    logic [15:0] seq_mag [4];
    logic [16:0] seq_exp [4];

    initial begin
        vectors       = 0;
        errors        = 0;
        n_rst         = 1'b0;
        bus.sign_push = 1'b0;
        bus.sign_in   = 1'b0;
        bus.mag_valid = 1'b0;
        bus.mag_in    = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        n_rst = 1'b1;
        tick();

        // Single conversions, including extremes and negative zero.
        xfer("neg5",    1'b1, 16'd5,     17'h1FFFB, 1'b0);
        xfer("pos5",    1'b0, 16'd5,     17'h00005, 1'b0);
`ifdef SIGN_RESTORE_SAT16_EN
        xfer("posmax",  1'b0, 16'hFFFF,  17'h07FFF, 1'b1);
        xfer("negmax",  1'b1, 16'hFFFF,  17'h18000, 1'b1);
        xfer("negzero", 1'b1, 16'h0000,  17'h00000, 1'b0);
        xfer("sat_pos", 1'b0, 16'd40000, 17'h07FFF, 1'b1);
        xfer("sat_n32768", 1'b1, 16'd32768, 17'h18000, 1'b0);
        xfer("sat_n32769", 1'b1, 16'd32769, 17'h18000, 1'b1);
`else
        xfer("posmax",  1'b0, 16'hFFFF,  17'h0FFFF, 1'b0);
        xfer("negmax",  1'b1, 16'hFFFF,  17'h10001, 1'b0);
        xfer("negzero", 1'b1, 16'h0000,  17'h00000, 1'b0);
        xfer("wide_pos", 1'b0, 16'd40000, 17'h09C40, 1'b0);
        xfer("n32768",  1'b1, 16'd32768, 17'h18000, 1'b0);
        xfer("n32769",  1'b1, 16'd32769, 17'h17FFF, 1'b0);
`endif

        // Ordered back-to-back results: signs 1,0,1,0 with mags 1..4.
        push(1'b1);
        push(1'b0);
        push(1'b1);
        push(1'b0);
        chk("b2b_count", 32'(bus.sign_count), 32'd4);
        chk("b2b_full",  32'(bus.sign_full),  32'd1);
        seq_mag[0] = 16'd1; seq_exp[0] = 17'h1FFFF;
        seq_mag[1] = 16'd2; seq_exp[1] = 17'h00002;
        seq_mag[2] = 16'd3; seq_exp[2] = 17'h1FFFD;
        seq_mag[3] = 16'd4; seq_exp[3] = 17'h00004;
        bus.mag_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mag_in = seq_mag[i];
            tick();
            chk($sformatf("b2b_valid%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("b2b_data%0d", i),  32'(bus.out_data),  32'(seq_exp[i]));
        end
        bus.mag_valid = 1'b0;
        chk("b2b_empty", 32'(bus.sign_count), 32'd0);
        tick();
        chk("b2b_drain", 32'(bus.out_valid), 32'd0);

        // Fill, overflow, then push+pop at full.
        push(1'b0);
        push(1'b0);
        push(1'b0);
        push(1'b0);
        chk("full_flag",  32'(bus.sign_full),  32'd1);
        chk("full_count", 32'(bus.sign_count), 32'd4);
        chk("full_noerr", 32'(bus.sign_err),   32'd0);
        push(1'b1);
        chk("ovf_err",   32'(bus.sign_err),   32'd1);
        chk("ovf_count", 32'(bus.sign_count), 32'd4);
        bus.sign_push = 1'b1;
        bus.sign_in   = 1'b1;
        bus.mag_valid = 1'b1;
        bus.mag_in    = 16'd7;
        #1;
        chk("pp_ready", 32'(bus.mag_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.sign_push = 1'b0;
        bus.mag_valid = 1'b0;
        chk("pp_count", 32'(bus.sign_count), 32'd4);
        chk("pp_err",   32'(bus.sign_err),   32'd1);
        chk("pp_data",  32'(bus.out_data),   32'h00007);

        // Downstream stall holds the output and blocks the next result.
        bus.out_ready = 1'b0;
        bus.mag_valid = 1'b1;
        bus.mag_in    = 16'd9;
        #1;
        chk("stall_ready", 32'(bus.mag_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_valid%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall_data%0d", i),  32'(bus.out_data),  32'h00007);
        end
        chk("stall_count", 32'(bus.sign_count), 32'd4);
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(bus.mag_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.mag_valid = 1'b0;
        chk("unstall_data",  32'(bus.out_data),   32'h00009);
        chk("unstall_count", 32'(bus.sign_count), 32'd3);

        // Reset with three signs queued and valid output pending.
        #2;
        n_rst = 1'b0;
        #2;
        check_reset_values("midrst");
        n_rst = 1'b1;
        tick();

        // Magnitude arriving before its sign waits without error.
        bus.mag_valid = 1'b1;
        bus.mag_in    = 16'd3;
        #1;
        chk("empty_ready", 32'(bus.mag_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("empty_valid", 32'(bus.out_valid), 32'd0);
        chk("empty_err",   32'(bus.sign_err),  32'd0);
        bus.sign_push = 1'b1;
        bus.sign_in   = 1'b1;
        #1;
        chk("pushpop_zero_ready", 32'(bus.mag_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.sign_push = 1'b0;
        chk("late_sign_valid", 32'(bus.out_valid),  32'd0);
        chk("late_sign_count", 32'(bus.sign_count), 32'd1);
        chk("late_sign_ready", 32'(bus.mag_ready),  32'd1);
        @(posedge clk);
        #1;
        bus.mag_valid = 1'b0;
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data",  32'(bus.out_data),  32'h1FFFD);
        chk("post_rst_count", 32'(bus.sign_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
